// File: rtl/frame_cfg_writer.sv
// Configuration frame writer: turns a header + NumRows data-word stream into FrameData rows
// and a one-cycle, one-hot FrameStrobe pulse on the addressed column/frame.
module frame_cfg_writer #(
  parameter int unsigned  MaxFramesPerCol = 20,
  parameter int unsigned  FrameBitsPerRow = 32,
  parameter int unsigned  NumRows         = 16,
  parameter int unsigned  NumColumns      = 10,
  parameter logic [7:0]   SyncByte        = 8'hFA
) (
  input  logic                                  UserCLK,
  input  logic                                  resetn,
  input  logic [FrameBitsPerRow-1:0]            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err_hdr,
  input  logic                                  clr_err,
  output logic [15:0]                           frame_count
);

  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned StrobeW = NumColumns * MaxFramesPerCol;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE
  } state_e;

  state_e                                      state_q, state_d;
  logic [RowW-1:0]                             row_cnt_q, row_cnt_d;
  logic [7:0]                                  col_q, col_d;
  logic [7:0]                                  frame_q, frame_d;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]     frame_data_q;
  logic [StrobeW-1:0]                          strobe_q, strobe_d;
  logic                                        in_ready_q, in_ready_d;
  logic                                        busy_q, busy_d;
  logic                                        err_q, err_d;
  logic [15:0]                                 frame_count_q, frame_count_d;

  logic xfer;
  logic hdr_ok;
  logic wr_en;
  logic enter_strobe;
  logic err_set;
  logic unused_hdr_bits;

  // Header bits [23:16] carry no meaning for this block.
  assign unused_hdr_bits = ^in_data[23:16];

  assign xfer   = in_valid && in_ready_q;
  assign hdr_ok = (in_data[31:24] == SyncByte)
               && (32'(in_data[15:8]) < NumColumns)
               && (32'(in_data[7:0])  < MaxFramesPerCol);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    col_d         = col_q;
    frame_d       = frame_q;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    enter_strobe  = 1'b0;
    err_set       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok) begin
            col_d     = in_data[15:8];
            frame_d   = in_data[7:0];
            row_cnt_d = '0;
            state_d   = LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (row_cnt_q == RowW'(NumRows - 1)) begin
            enter_strobe = 1'b1;
            state_d      = STROBE;
          end else begin
            row_cnt_d = row_cnt_q + RowW'(1);
          end
        end
      end
      STROBE: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh error outranks a simultaneous clear.
    err_d      = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
    in_ready_d = (state_d != STROBE);
    busy_d     = (state_d != IDLE);
  end

  // One-hot strobe decode; only driven on the edge that enters STROBE, so it lasts one cycle.
  for (genvar c = 0; c < NumColumns; c++) begin : g_col
    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
      assign strobe_d[c*MaxFramesPerCol + f] = enter_strobe
                                            && (32'(col_q) == c)
                                            && (32'(frame_q) == f);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: FrameData is cleared on reset because the fabric sees it directly.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      row_cnt_q     <= '0;
      col_q         <= '0;
      frame_q       <= '0;
      frame_data_q  <= '0;
      strobe_q      <= '0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      col_q         <= col_d;
      frame_q       <= frame_d;
      strobe_q      <= strobe_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
      if (wr_en) begin
        frame_data_q[row_cnt_q] <= in_data;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign FrameData   = frame_data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = busy_q;
  assign err_hdr     = err_q;
  assign frame_count = frame_count_q;

endmodule
